// File: rtl/dmem_bus_adapter.sv
// Data-memory bus adapter: turns one MEM-stage load/store into a single-outstanding
// valid/ready bus transaction, stalling the pipeline until it completes or times out.
module dmem_bus_adapter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [2:0]  funct3,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        access_fault,
    output logic        bus_error,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rdata
);

    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StReq, StRsp, StDone} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] read_data_q, read_data_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_wstrb_q, bus_wstrb_d;
    logic        bus_we_q, bus_we_d;
    logic        req_valid_q, req_valid_d;
    logic        bus_error_q, bus_error_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  offset_q, offset_d;

    logic        access;
    logic        illegal;
    logic        misaligned;
    logic        fault;
    logic        legal_access;
    logic        timeout;
    logic [3:0]  strb;
    logic [31:0] wdata_lanes;
    logic [7:0]  rsp_byte;
    logic [15:0] rsp_half;
    logic [31:0] load_ext;

    always_comb begin
        access  = mem_read | mem_write;
        illegal = 1'b0;
        if (mem_read && mem_write) begin
            illegal = 1'b1;
        end else if (mem_read) begin
            illegal = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end else if (mem_write) begin
            illegal = !(funct3 inside {3'b000, 3'b001, 3'b010});
        end
        // funct3[1:0] encodes the size for both signed and unsigned loads
        misaligned   = ((funct3[1:0] == 2'b01) && address[0]) ||
                       ((funct3[1:0] == 2'b10) && (address[1:0] != 2'b00));
        fault        = access && (illegal || misaligned);
        legal_access = access && !fault;
    end

    always_comb begin
        strb        = 4'b1111;
        wdata_lanes = write_data;
        unique case (funct3[1:0])
            2'b00: begin
                strb        = 4'b0001 << address[1:0];
                wdata_lanes = {4{write_data[7:0]}};
            end
            2'b01: begin
                strb        = 4'b0011 << address[1:0];
                wdata_lanes = {2{write_data[15:0]}};
            end
            default: begin
                strb        = 4'b1111;
                wdata_lanes = write_data;
            end
        endcase
    end

    always_comb begin
        rsp_byte = bus_rdata[{offset_q, 3'b000} +: 8];
        rsp_half = offset_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{rsp_byte[7]}}, rsp_byte};
            3'b001:  load_ext = {{16{rsp_half[15]}}, rsp_half};
            3'b100:  load_ext = {24'b0, rsp_byte};
            3'b101:  load_ext = {16'b0, rsp_half};
            default: load_ext = bus_rdata;
        endcase
    end

    assign timeout = (cnt_q == TimeoutLast);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        read_data_d = read_data_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wstrb_d = bus_wstrb_q;
        bus_we_d    = bus_we_q;
        req_valid_d = req_valid_q;
        bus_error_d = 1'b0;
        funct3_d    = funct3_q;
        offset_d    = offset_q;

        unique case (state_q)
            StIdle: begin
                if (legal_access) begin
                    state_d     = StReq;
                    cnt_d       = 16'd0;
                    bus_addr_d  = {address[31:2], 2'b00};
                    bus_we_d    = mem_write;
                    bus_wstrb_d = mem_write ? strb : 4'b0000;
                    bus_wdata_d = mem_write ? wdata_lanes : 32'd0;
                    req_valid_d = 1'b1;
                    funct3_d    = funct3;
                    offset_d    = address[1:0];
                end else begin
                    read_data_d = 32'd0;
                end
            end
            StReq: begin
                cnt_d = cnt_q + 16'd1;
                if (timeout) begin
                    state_d     = StDone;
                    req_valid_d = 1'b0;
                    bus_error_d = 1'b1;
                    read_data_d = 32'd0;
                end else if (bus_req_ready) begin
                    state_d     = StRsp;
                    req_valid_d = 1'b0;
                end
            end
            StRsp: begin
                cnt_d = cnt_q + 16'd1;
                // A response arriving in the timeout cycle still completes normally
                if (bus_rsp_valid) begin
                    state_d     = StDone;
                    read_data_d = bus_we_q ? 32'd0 : load_ext;
                end else if (timeout) begin
                    state_d     = StDone;
                    bus_error_d = 1'b1;
                    read_data_d = 32'd0;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 16'd0;
            read_data_q <= 32'd0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            bus_wstrb_q <= 4'b0000;
            bus_we_q    <= 1'b0;
            req_valid_q <= 1'b0;
            bus_error_q <= 1'b0;
            funct3_q    <= 3'b000;
            offset_q    <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            read_data_q <= read_data_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wstrb_q <= bus_wstrb_d;
            bus_we_q    <= bus_we_d;
            req_valid_q <= req_valid_d;
            bus_error_q <= bus_error_d;
            funct3_q    <= funct3_d;
            offset_q    <= offset_d;
        end
    end

    assign access_fault  = !rst && (state_q == StIdle) && fault;
    assign stall         = !rst && (((state_q == StIdle) && legal_access) ||
                                    (state_q == StReq) || (state_q == StRsp));
    assign read_data     = ((state_q == StIdle) && fault) ? 32'd0 : read_data_q;
    assign bus_error     = bus_error_q;
    assign bus_req_valid = req_valid_q;
    assign bus_addr      = bus_addr_q;
    assign bus_we        = bus_we_q;
    assign bus_wstrb     = bus_wstrb_q;
    assign bus_wdata     = bus_wdata_q;

endmodule

// File: tb/tb_dmem_bus_adapter.sv
// Self-checking bench for dmem_bus_adapter: a small bus slave driven from tasks, with
// expected load results queued at stimulus time and popped when the access completes.
module tb_dmem_bus_adapter;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [31:0] address, write_data;
    logic [2:0]  funct3;
    logic [31:0] read_data;
    logic        stall, access_fault, bus_error;
    logic        bus_req_valid, bus_req_ready;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_rsp_valid;
    logic [31:0] bus_rdata;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    dmem_bus_adapter #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .address      (address),
        .write_data   (write_data),
        .funct3       (funct3),
        .read_data    (read_data),
        .stall        (stall),
        .access_fault (access_fault),
        .bus_error    (bus_error),
        .bus_req_valid(bus_req_valid),
        .bus_req_ready(bus_req_ready),
        .bus_addr     (bus_addr),
        .bus_we       (bus_we),
        .bus_wstrb    (bus_wstrb),
        .bus_wdata    (bus_wdata),
        .bus_rsp_valid(bus_rsp_valid),
        .bus_rdata    (bus_rdata)
    );

    // Called just after a rising edge in an IDLE cycle; returns just after the edge ending DONE.
    task automatic run_access(
        input  logic        rd,
        input  logic        wr,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  logic [2:0]  f3,
        input  logic [31:0] rdata,
        input  int          ready_wait,
        input  int          rsp_wait,
        output int          stall_cycles,
        output logic [31:0] rd_out,
        output logic        err,
        output logic [31:0] a_out,
        output logic        we_out,
        output logic [3:0]  strb_out,
        output logic [31:0] wd_out,
        output logic        stable,
        output logic        done
    );
        int   req_cnt, rsp_cnt;
        logic hs_prev, rsp_prev, in_rsp, seen_valid;
        req_cnt = 0; rsp_cnt = 0; hs_prev = 0; rsp_prev = 0; in_rsp = 0; seen_valid = 0;
        stall_cycles = 0; rd_out = 'x; err = 'x; a_out = 'x; we_out = 'x; strb_out = 'x;
        wd_out = 'x; stable = 1'b1; done = 1'b0;
        mem_read = rd; mem_write = wr; address = addr; write_data = wdata; funct3 = f3;
        bus_rdata = rdata;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (c > 0 && !stall) begin
                rd_out = read_data;
                err    = bus_error;
                done   = 1'b1;
                break;
            end
            if (stall) stall_cycles++;
            if (hs_prev) in_rsp = 1'b1;
            if (rsp_prev) in_rsp = 1'b0;
            if (bus_req_valid) begin
                if (!seen_valid) begin
                    a_out = bus_addr; we_out = bus_we; strb_out = bus_wstrb; wd_out = bus_wdata;
                end else if ({a_out, we_out, strb_out, wd_out} !==
                             {bus_addr, bus_we, bus_wstrb, bus_wdata}) begin
                    stable = 1'b0;
                end
                seen_valid    = 1'b1;
                bus_req_ready = (req_cnt >= ready_wait);
                req_cnt++;
            end else begin
                bus_req_ready = 1'b0;
            end
            hs_prev = bus_req_valid && bus_req_ready;
            if (in_rsp) begin
                bus_rsp_valid = (rsp_cnt >= rsp_wait);
                rsp_cnt++;
            end else begin
                bus_rsp_valid = 1'b0;
            end
            rsp_prev = in_rsp && bus_rsp_valid;
        end
        mem_read = 1'b0; mem_write = 1'b0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_read = 0; mem_write = 0; address = 0; write_data = 0; funct3 = 0;
        bus_req_ready = 0; bus_rsp_valid = 0; bus_rdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({read_data, bus_addr, bus_wdata, bus_wstrb, bus_req_valid, bus_we, access_fault,
             bus_error, stall} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: rd=%h addr=%h wd=%h strb=%b v=%b we=%b af=%b be=%b st=%b, required all 0",
                     read_data, bus_addr, bus_wdata, bus_wstrb, bus_req_valid, bus_we,
                     access_fault, bus_error, stall);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lw();
        int sc; logic [31:0] rd, a, wd; logic er, we, stb, dn; logic [3:0] sb;
        exp_q.push_back(32'hDEADBEEF);
        run_access(1, 0, 32'h100, 0, 3'b010, 32'hDEADBEEF, 0, 0, sc, rd, er, a, we, sb, wd, stb, dn);
        checks++;
        if (rd !== exp_q.pop_front() || !dn) begin
            failures++; $display("FAIL lw_data: got %h done=%b, required deadbeef", rd, dn);
        end
        checks++;
        if (sc !== 3) begin failures++; $display("FAIL lw_stall_cycles: got %0d, required 3", sc); end
        checks++;
        if ({a, we, sb, er} !== {32'h100, 1'b0, 4'b0000, 1'b0}) begin
            failures++; $display("FAIL lw_bus_fields: addr=%h we=%b strb=%b err=%b, required 100/0/0000/0", a, we, sb, er);
        end
    endtask

    task automatic test_sub_word_loads();
        int sc; logic [31:0] rd, a, wd; logic er, we, stb, dn; logic [3:0] sb;
        logic [2:0]  f3s   [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] addrs [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
        logic [31:0] exps  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(exps[i]);
            run_access(1, 0, addrs[i], 0, f3s[i], 32'h80FF0102, 0, 0, sc, rd, er, a, we, sb, wd, stb, dn);
            checks++;
            if (rd !== exp_q.pop_front() || a !== 32'h100) begin
                failures++;
                $display("FAIL subword_load_%0d: got data %h addr %h, required %h addr 00000100", i, rd, a, exps[i]);
            end
        end
    endtask

    task automatic test_stores();
        int sc; logic [31:0] rd, a, wd; logic er, we, stb, dn; logic [3:0] sb;
        logic [2:0]  f3s [3] = '{3'b001, 3'b000, 3'b010};
        logic [31:0] ads [3] = '{32'h202, 32'h201, 32'h300};
        logic [31:0] wds [3] = '{32'h1234ABCD, 32'h0000005A, 32'hCAFEF00D};
        logic [31:0] ea  [3] = '{32'h200, 32'h200, 32'h300};
        logic [3:0]  es  [3] = '{4'b1100, 4'b0010, 4'b1111};
        logic [31:0] ew  [3] = '{32'hABCDABCD, 32'h5A5A5A5A, 32'hCAFEF00D};
        for (int i = 0; i < 3; i++) begin
            run_access(0, 1, ads[i], wds[i], f3s[i], 0, 0, 0, sc, rd, er, a, we, sb, wd, stb, dn);
            checks++;
            if ({a, we, sb, wd, dn} !== {ea[i], 1'b1, es[i], ew[i], 1'b1}) begin
                failures++;
                $display("FAIL store_%0d: addr=%h we=%b strb=%b wdata=%h done=%b, required %h/1/%b/%h/1",
                         i, a, we, sb, wd, dn, ea[i], es[i], ew[i]);
            end
        end
    endtask

    task automatic test_wait_states();
        int sc; logic [31:0] rd, a, wd; logic er, we, stb, dn; logic [3:0] sb;
        exp_q.push_back(32'h00005678);
        run_access(1, 0, 32'h40, 0, 3'b101, 32'h12345678, 2, 1, sc, rd, er, a, we, sb, wd, stb, dn);
        checks++;
        if (rd !== exp_q.pop_front() || sc !== 6 || !stb) begin
            failures++;
            $display("FAIL wait_states: data=%h stall_cycles=%0d stable=%b, required 00005678/6/1", rd, sc, stb);
        end
    endtask

    task automatic test_back_to_back_and_fault();
        int sc1, sc2; logic [31:0] rd1, rd2, a, wd; logic er, we, stb, dn; logic [3:0] sb;
        logic saw_valid;
        logic [2:0]  f3s [3] = '{3'b010, 3'b011, 3'b010};
        logic        wrs [3] = '{1'b0, 1'b0, 1'b1};
        exp_q.push_back(32'h11111111);
        exp_q.push_back(32'h22222222);
        run_access(1, 0, 32'h10, 0, 3'b010, 32'h11111111, 0, 0, sc1, rd1, er, a, we, sb, wd, stb, dn);
        run_access(1, 0, 32'h14, 0, 3'b010, 32'h22222222, 0, 0, sc2, rd2, er, a, we, sb, wd, stb, dn);
        checks++;
        if (rd1 !== exp_q.pop_front() || sc1 !== 3) begin
            failures++; $display("FAIL b2b_first: data=%h stall=%0d, required 11111111/3", rd1, sc1);
        end
        checks++;
        if (rd2 !== exp_q.pop_front() || sc2 !== 3) begin
            failures++; $display("FAIL b2b_second: data=%h stall=%0d, required 22222222/3", rd2, sc2);
        end
        // Immediately after DONE, the held load value must be masked by the fault.
        mem_read = 1'b1; address = 32'h101; funct3 = 3'b010;
        #1;
        checks++;
        if ({access_fault, stall, read_data} !== {1'b1, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL misaligned_lw: fault=%b stall=%b data=%h, required 1/0/00000000",
                     access_fault, stall, read_data);
        end
        @(posedge clk); #1;
        mem_read = 1'b0;
        saw_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw_valid = saw_valid | bus_req_valid;
        end
        checks++;
        if ({saw_valid, access_fault, read_data} !== {1'b0, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL misaligned_after: req_valid_seen=%b fault=%b data=%h, required 0/0/0",
                     saw_valid, access_fault, read_data);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            mem_read = 1'b1; mem_write = wrs[i]; address = 32'h100 + 32'(i); funct3 = f3s[i];
            if (i == 0) address = 32'h102;
            if (i == 1) address = 32'h100;
            if (i == 2) address = 32'h100;
            #1;
            checks++;
            if ({access_fault, stall} !== 2'b10) begin
                failures++;
                $display("FAIL illegal_%0d: fault=%b stall=%b, required 1/0", i, access_fault, stall);
            end
        end
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        int sc; logic [31:0] rd, a, wd; logic er, we, stb, dn; logic [3:0] sb;
        int rw [2] = '{1000, 0};
        int pw [2] = '{0, 1000};
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(32'h0);
            run_access(1, 0, 32'h80, 0, 3'b010, 32'hFFFFFFFF, rw[i], pw[i], sc, rd, er, a, we, sb, wd, stb, dn);
            checks++;
            if ({dn, er, rd} !== {1'b1, 1'b1, exp_q.pop_front()} || sc !== 9) begin
                failures++;
                $display("FAIL timeout_%0d: done=%b err=%b data=%h stall_cycles=%0d, required 1/1/00000000/9",
                         i, dn, er, rd, sc);
            end
            @(negedge clk);
            checks++;
            if ({bus_error, stall, bus_req_valid} !== 3'b000) begin
                failures++;
                $display("FAIL timeout_idle_%0d: err=%b stall=%b valid=%b, required 0/0/0",
                         i, bus_error, stall, bus_req_valid);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_rsp();
        int sc; logic [31:0] rd, a, wd; logic er, we, stb, dn; logic [3:0] sb;
        mem_read = 1'b1; mem_write = 1'b0; address = 32'h124; funct3 = 3'b010;
        bus_rdata = 32'h12345678; bus_req_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus_req_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({stall, bus_req_valid} !== 2'b10) begin
            failures++; $display("FAIL in_rsp: stall=%b valid=%b, required 1/0", stall, bus_req_valid);
        end
        @(posedge clk); #1;
        rst = 1'b1; mem_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        bus_rsp_valid = 1'b1;
        @(posedge clk); #1;
        bus_rsp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({read_data, bus_addr, bus_wdata, bus_wstrb, bus_req_valid, bus_we, access_fault,
             bus_error, stall} !== '0) begin
            failures++;
            $display("FAIL reset_mid_rsp: rd=%h addr=%h wd=%h strb=%b v=%b we=%b af=%b be=%b st=%b, required all 0",
                     read_data, bus_addr, bus_wdata, bus_wstrb, bus_req_valid, bus_we,
                     access_fault, bus_error, stall);
        end
        @(posedge clk); #1;
        exp_q.push_back(32'hFFFFFF87);
        run_access(1, 0, 32'h21, 0, 3'b000, 32'h00008700, 0, 0, sc, rd, er, a, we, sb, wd, stb, dn);
        checks++;
        if (rd !== exp_q.pop_front() || sc !== 3) begin
            failures++; $display("FAIL after_reset_lb: data=%h stall=%0d, required ffffff87/3", rd, sc);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sub_word_loads();
        test_stores();
        test_wait_states();
        test_back_to_back_and_fault();
        test_timeout();
        test_reset_mid_rsp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
